// File: rtl/am_pkg.sv
// Shared constants and state encoding for the associative-memory scoring sequencer.
package am_pkg;
    localparam int CLASS_W  = 5;
    localparam int SAMPLE_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_INF = 3'd3,
        ST_TALLY    = 3'd4,
        ST_DONE     = 3'd5
    } am_seq_state_t;
endpackage

// File: rtl/am_label_sequencer.sv
// Fetches one ground-truth label per sample, pairs it with the AM inference and
// emits a single aligned tally strobe per sample until the programmed count is reached.
module am_label_sequencer
    import am_pkg::*;
#(
    parameter int CLASS_W  = am_pkg::CLASS_W,
    parameter int SAMPLE_W = am_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] num_samples,
    output logic                label_rd_en,
    output logic [SAMPLE_W-1:0] label_addr,
    input  logic [CLASS_W-1:0]  label_data,
    input  logic                infer_valid,
    input  logic [CLASS_W-1:0]  infer_class,
    output logic                infer_ready,
    output logic                tallying_accuracy,
    output logic [CLASS_W-1:0]  correct_class,
    output logic [CLASS_W-1:0]  class_inference,
    output logic [SAMPLE_W-1:0] sample_index,
    output logic                busy,
    output logic                done
);

    am_seq_state_t       state_reg, state_next;
    logic [SAMPLE_W-1:0] count_reg;
    logic [CLASS_W-1:0]  label_reg;
    logic                start_ok;
    logic                last_sample;
    logic                handshake;

    assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    // count_reg is never zero while in TALLY, so the subtraction cannot underflow there
    assign last_sample = (sample_index == count_reg - SAMPLE_W'(1));
    assign handshake   = (state_reg == ST_WAIT_INF) && infer_valid;

    always_comb begin
        state_next  = state_reg;
        label_rd_en = 1'b0;
        label_addr  = sample_index;
        infer_ready = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (num_samples == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                label_rd_en = 1'b1;
                state_next  = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_WAIT_INF;
            end
            ST_WAIT_INF: begin
                infer_ready = 1'b1;
                if (infer_valid) begin
                    state_next = ST_TALLY;
                end
            end
            ST_TALLY: begin
                state_next = last_sample ? ST_DONE : ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg         <= ST_IDLE;
            count_reg         <= '0;
            label_reg         <= '0;
            sample_index      <= '0;
            correct_class     <= '0;
            class_inference   <= '0;
            tallying_accuracy <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state_reg         <= state_next;
            tallying_accuracy <= handshake;
            busy              <= !(state_next == ST_IDLE || state_next == ST_DONE);
            done              <= (state_next == ST_DONE);

            if (start_ok) begin
                count_reg    <= num_samples;
                sample_index <= '0;
            end

            // read data arrives the cycle after FETCH, i.e. while in LOAD
            if (state_reg == ST_LOAD) begin
                label_reg <= label_data;
            end

            if (handshake) begin
                class_inference <= infer_class;
                correct_class   <= label_reg;
            end

            if (state_reg == ST_TALLY && !last_sample) begin
                sample_index <= sample_index + SAMPLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_am_label_sequencer.sv
// Randomized bench for am_label_sequencer: a label-memory responder, a cycle-level
// inference driver and a timing/value model derived from the per-sample schedule.
`timescale 1ns/1ps
module tb_am_label_sequencer;
    import am_pkg::*;

    localparam int CW = CLASS_W;
    localparam int SW = SAMPLE_W;

    logic          clk;
    logic          nrst;
    logic          start;
    logic [SW-1:0] num_samples;
    logic          label_rd_en;
    logic [SW-1:0] label_addr;
    logic [CW-1:0] label_data;
    logic          infer_valid;
    logic [CW-1:0] infer_class;
    logic          infer_ready;
    logic          tallying_accuracy;
    logic [CW-1:0] correct_class;
    logic [CW-1:0] class_inference;
    logic [SW-1:0] sample_index;
    logic          busy;
    logic          done;

    am_label_sequencer #(.CLASS_W(CW), .SAMPLE_W(SW)) dut (
        .clk(clk), .nrst(nrst), .start(start), .num_samples(num_samples),
        .label_rd_en(label_rd_en), .label_addr(label_addr), .label_data(label_data),
        .infer_valid(infer_valid), .infer_class(infer_class), .infer_ready(infer_ready),
        .tallying_accuracy(tallying_accuracy), .correct_class(correct_class),
        .class_inference(class_inference), .sample_index(sample_index),
        .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // label memory: data valid exactly one cycle after the read strobe, garbage otherwise
    logic [CW-1:0] label_mem [0:2047];
    always @(posedge clk) label_data <= label_rd_en ? label_mem[label_addr] : CW'($urandom);

    logic [CW-1:0] inf_mem [0:2047];
    int            delay_mem [0:2047];
    bit            always_high;
    int            busy_start_sample = -1;
    int            abort_sample      = -1;

    // observations of one run
    int            st_cyc[$];
    logic [CW-1:0] st_cor[$];
    logic [CW-1:0] st_inf[$];
    logic [SW-1:0] st_idx[$];
    logic [SW-1:0] rd_addr[$];
    int            start_cyc, done_cyc, ready_cycles;
    bit            timed_out;
    logic          done_after_start;

    // expectations of one run
    int            exp_cyc[$];
    int            exp_done, exp_ready, exp_tally;

    function automatic void model(input int n);
        int f;
        int d;
        exp_cyc.delete();
        exp_ready = 0;
        exp_tally = 0;
        f = start_cyc + 1;
        for (int j = 0; j < n; j++) begin
            d = always_high ? 0 : delay_mem[j];
            exp_cyc.push_back(f + 3 + d);
            exp_ready += d + 1;
            if (label_mem[j] == inf_mem[j]) exp_tally++;
            f += 4 + d;
        end
        exp_done = (n == 0) ? start_cyc + 1 : exp_cyc[n-1] + 1;
    endfunction

    function automatic int obs_tally();
        int t = 0;
        foreach (st_cor[i]) if (st_cor[i] == st_inf[i]) t++;
        return t;
    endfunction

    function automatic void randomize_samples(input int n, input int max_delay);
        for (int j = 0; j < n; j++) begin
            label_mem[j] = CW'($urandom);
            inf_mem[j]   = ($urandom_range(0, 1) == 1) ? label_mem[j] : CW'($urandom);
            delay_mem[j] = $urandom_range(0, max_delay);
        end
    endfunction

    task automatic drive_run(input int n);
        int k  = 0;
        int rc = 0;
        st_cyc.delete(); st_cor.delete(); st_inf.delete(); st_idx.delete(); rd_addr.delete();
        done_cyc = -1; ready_cycles = 0; timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1; num_samples = SW'(n); start_cyc = cyc;
        infer_valid = always_high; infer_class = inf_mem[0];
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            start = 1'b0; num_samples = SW'($urandom);
            if (t == 0) done_after_start = done;
            if (tallying_accuracy) begin
                st_cyc.push_back(cyc); st_cor.push_back(correct_class);
                st_inf.push_back(class_inference); st_idx.push_back(sample_index);
            end
            if (label_rd_en) rd_addr.push_back(label_addr);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (infer_ready) begin
                ready_cycles++;
                rc++;
            end
            if (abort_sample == k && infer_ready) begin
                infer_valid = 1'b0;
                nrst = 1'b0;
                return;
            end
            if (busy_start_sample == k && infer_ready && rc == 1) begin
                start = 1'b1; num_samples = SW'(n + 3);
            end
            infer_valid = always_high || (infer_ready && rc > delay_mem[k]);
            infer_class = inf_mem[k];
            if (infer_valid && infer_ready) begin
                k++;
                rc = 0;
            end
        end
        if (done_cyc < 0) timed_out = 1'b1;
        @(negedge clk);
        infer_valid = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; num_samples = '0; infer_valid = 1'b0; infer_class = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({label_rd_en, label_addr, infer_ready, tallying_accuracy, correct_class,
             class_inference, sample_index, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rd=%b addr=%0d rdy=%b str=%b cc=%0d ci=%0d idx=%0d busy=%b done=%b want all 0",
                     label_rd_en, label_addr, infer_ready, tallying_accuracy, correct_class,
                     class_inference, sample_index, busy, done);
        end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, label_rd_en} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b rd=%b want 0 0 0", busy, done, label_rd_en);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_basic();
        int lab[3] = '{3, 7, 1};
        int inf[3] = '{3, 7, 2};
        always_high = 1'b1;
        for (int j = 0; j < 3; j++) begin
            label_mem[j] = CW'(lab[j]); inf_mem[j] = CW'(inf[j]); delay_mem[j] = 0;
        end
        drive_run(3);
        model(3);
        total++;
        if (timed_out || st_cyc.size() != 3) begin
            bad++;
            $display("FAIL basic_count got strobes=%0d timeout=%0d want 3 0", st_cyc.size(), timed_out);
        end
        for (int i = 0; i < st_cyc.size() && i < 3; i++) begin
            total++;
            if ({st_cyc[i], st_cor[i], st_inf[i], st_idx[i]} !==
                {exp_cyc[i], CW'(lab[i]), CW'(inf[i]), SW'(i)}) begin
                bad++;
                $display("FAIL basic_strobe%0d got cyc=%0d cc=%0d ci=%0d idx=%0d want cyc=%0d cc=%0d ci=%0d idx=%0d",
                         i, st_cyc[i], st_cor[i], st_inf[i], st_idx[i], exp_cyc[i], lab[i], inf[i], i);
            end
        end
        total++;
        if (obs_tally() != 2 || done_cyc != exp_done) begin
            bad++;
            $display("FAIL basic_tally_done got tally=%0d done_cyc=%0d want tally=2 done_cyc=%0d",
                     obs_tally(), done_cyc, exp_done);
        end
        total++;
        if (rd_addr.size() != 3 || rd_addr[0] !== 0 || rd_addr[1] !== 1 || rd_addr[2] !== 2) begin
            bad++;
            $display("FAIL basic_reads got n=%0d want 3 reads at 0,1,2", rd_addr.size());
        end
        $display("test_basic: strobes=%0d tally=%0d", st_cyc.size(), obs_tally());
    endtask

    task automatic test_stall();
        always_high = 1'b0;
        randomize_samples(2, 0);
        inf_mem[0] = CW'(9); delay_mem[0] = 10;
        drive_run(2);
        model(2);
        total++;
        if (timed_out || st_cyc.size() != 2 || ready_cycles != exp_ready) begin
            bad++;
            $display("FAIL stall_count got strobes=%0d ready_cycles=%0d timeout=%0d want 2 %0d 0",
                     st_cyc.size(), ready_cycles, timed_out, exp_ready);
        end
        if (st_cyc.size() >= 1) begin
            total++;
            if (st_cyc[0] != exp_cyc[0] || st_inf[0] !== CW'(9) || st_cor[0] !== label_mem[0]) begin
                bad++;
                $display("FAIL stall_strobe got cyc=%0d ci=%0d cc=%0d want cyc=%0d ci=9 cc=%0d",
                         st_cyc[0], st_inf[0], st_cor[0], exp_cyc[0], label_mem[0]);
            end
        end
        $display("test_stall: ready_cycles=%0d", ready_cycles);
    endtask

    task automatic test_zero();
        drive_run(0);
        total++;
        if (done_after_start !== 1'b1 || done_cyc != start_cyc + 1 || rd_addr.size() != 0 || st_cyc.size() != 0) begin
            bad++;
            $display("FAIL zero_run got done_next=%b done_cyc=%0d reads=%0d strobes=%0d want 1 %0d 0 0",
                     done_after_start, done_cyc, rd_addr.size(), st_cyc.size(), start_cyc + 1);
        end
        $display("test_zero: done_cyc=%0d", done_cyc);
    endtask

    task automatic test_start_busy();
        always_high = 1'b0;
        randomize_samples(3, 3);
        delay_mem[1] = 3;
        busy_start_sample = 1;
        drive_run(3);
        busy_start_sample = -1;
        model(3);
        total++;
        if (timed_out || st_cyc.size() != 3 || done_cyc != exp_done) begin
            bad++;
            $display("FAIL busy_start_count got strobes=%0d done_cyc=%0d want 3 %0d", st_cyc.size(), done_cyc, exp_done);
        end
        for (int i = 0; i < st_cyc.size() && i < 3; i++) begin
            total++;
            if (st_cyc[i] != exp_cyc[i] || st_idx[i] !== SW'(i)) begin
                bad++;
                $display("FAIL busy_start_strobe%0d got cyc=%0d idx=%0d want cyc=%0d idx=%0d",
                         i, st_cyc[i], st_idx[i], exp_cyc[i], i);
            end
        end
        randomize_samples(2, 2);
        drive_run(2);
        total++;
        if (done_after_start !== 1'b0 || st_cyc.size() != 2 || (st_idx.size() > 0 && st_idx[0] !== '0)) begin
            bad++;
            $display("FAIL rerun got done_next=%b strobes=%0d want done_next=0 strobes=2 first_idx=0",
                     done_after_start, st_cyc.size());
        end
        $display("test_start_busy: strobes=%0d", st_cyc.size());
    endtask

    task automatic test_abort();
        always_high = 1'b0;
        randomize_samples(3, 0);
        delay_mem[1] = 5;
        abort_sample = 1;
        drive_run(3);
        abort_sample = -1;
        #1;
        total++;
        if ({label_rd_en, label_addr, infer_ready, tallying_accuracy, correct_class,
             class_inference, sample_index, busy, done} !== '0 || st_cyc.size() != 1) begin
            bad++;
            $display("FAIL abort_outputs got rdy=%b idx=%0d busy=%b cc=%0d strobes=%0d want all 0 strobes=1",
                     infer_ready, sample_index, busy, correct_class, st_cyc.size());
        end
        repeat (2) @(negedge clk);
        total++;
        if (tallying_accuracy !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold got str=%b busy=%b want 0 0", tallying_accuracy, busy);
        end
        nrst = 1'b1;
        randomize_samples(2, 2);
        drive_run(2);
        model(2);
        total++;
        if (timed_out || st_cyc.size() != 2 || done_cyc != exp_done || obs_tally() != exp_tally) begin
            bad++;
            $display("FAIL abort_rerun got strobes=%0d done_cyc=%0d tally=%0d want 2 %0d %0d",
                     st_cyc.size(), done_cyc, obs_tally(), exp_done, exp_tally);
        end
        $display("test_abort: rerun strobes=%0d", st_cyc.size());
    endtask

    task automatic test_early_valid();
        always_high = 1'b1;
        randomize_samples(2, 0);
        drive_run(2);
        model(2);
        total++;
        if (st_cyc.size() != 2 || ready_cycles != 2 || st_cyc[0] != exp_cyc[0] || st_cyc[1] != exp_cyc[1] ||
            st_inf[0] !== inf_mem[0] || st_inf[1] !== inf_mem[1]) begin
            bad++;
            $display("FAIL early_valid got strobes=%0d ready_cycles=%0d want 2 strobes at %0d,%0d with 2 ready cycles",
                     st_cyc.size(), ready_cycles, exp_cyc[0], exp_cyc[1]);
        end
        $display("test_early_valid: ready_cycles=%0d", ready_cycles);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            always_high = ($urandom_range(0, 1) == 1);
            randomize_samples(n, 3);
            drive_run(n);
            model(n);
            total++;
            if (timed_out || st_cyc.size() != n || done_cyc != exp_done ||
                ready_cycles != exp_ready || obs_tally() != exp_tally || rd_addr.size() != n) begin
                bad++;
                $display("FAIL random%0d_summary got strobes=%0d done=%0d ready=%0d tally=%0d reads=%0d want %0d %0d %0d %0d %0d",
                         r, st_cyc.size(), done_cyc, ready_cycles, obs_tally(), rd_addr.size(),
                         n, exp_done, exp_ready, exp_tally, n);
            end
            for (int i = 0; i < st_cyc.size() && i < n; i++) begin
                total++;
                if ({st_cyc[i], st_cor[i], st_inf[i], st_idx[i]} !==
                    {exp_cyc[i], label_mem[i], inf_mem[i], SW'(i)}) begin
                    bad++;
                    $display("FAIL random%0d_strobe%0d got cyc=%0d cc=%0d ci=%0d idx=%0d want cyc=%0d cc=%0d ci=%0d idx=%0d",
                             r, i, st_cyc[i], st_cor[i], st_inf[i], st_idx[i],
                             exp_cyc[i], label_mem[i], inf_mem[i], i);
                end
            end
            $display("test_random[%0d]: n=%0d always_high=%0d strobes=%0d", r, n, always_high, st_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_start_busy();
        test_abort();
        test_early_valid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
